// File: rtl/video_palette.sv
// Palette lookup with a two-stage pixel pipeline and a reset-time grey-ramp fill.
// The host writes and reads entries back through the waddr port.
module video_palette #(
    parameter int IDXW = 4,
    parameter int CHW  = 6
) (
    input  logic              clock,
    input  logic              power,
    input  logic              ce_pix,
    input  logic              pixel,
    input  logic              blank,
    input  logic [IDXW-1:0]   color,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              mono,
    input  logic              wr,
    input  logic [IDXW-1:0]   waddr,
    input  logic [3*CHW-1:0]  wdata,
    input  logic              rd,
    output logic [3*CHW-1:0]  rdata,
    output logic [3*CHW-1:0]  rgb,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              ce_pix_o,
    output logic              busy
);

    localparam int DEPTH = 1 << IDXW;
    localparam int W     = 3 * CHW;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [CHW-1:0]  grey;
    logic [W-1:0]    pal [DEPTH];

    logic            s1_pix, s1_blank, s1_mono, s1_busy;
    logic            s1_hs, s1_vs, s1_ce;
    logic [W-1:0]    s1_ent;
    logic [CHW-1:0]  s1_green;
    logic            black;

    assign busy = (state_q == INIT);

    // Counter bits repeated MSB-first, truncated to the channel width.
    always_comb begin
        grey = '0;
        for (int b = 0; b < CHW; b++) begin
            grey[CHW-1-b] = cnt_q[IDXW-1-(b % IDXW)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {IDXW{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (busy) begin
            pal[cnt_q] <= {grey, grey, grey};
        end else if (wr) begin
            pal[waddr] <= wdata;
        end
    end

    // Lookups sample the array at the edge, so a same-edge write is not seen.
    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            s1_pix   <= 1'b0;
            s1_blank <= 1'b0;
            s1_mono  <= 1'b0;
            s1_busy  <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_ce    <= 1'b0;
            s1_ent   <= '0;
            rdata    <= '0;
        end else begin
            s1_pix   <= pixel;
            s1_blank <= blank;
            s1_mono  <= mono;
            s1_busy  <= busy;
            s1_hs    <= hsync;
            s1_vs    <= vsync;
            s1_ce    <= ce_pix;
            s1_ent   <= pal[color];
            if (!busy && rd) begin
                rdata <= pal[waddr];
            end
        end
    end

    assign s1_green = s1_ent[2*CHW-1:CHW];
    assign black    = busy | s1_busy | ~s1_pix | s1_blank;

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            rgb      <= '0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
            ce_pix_o <= 1'b0;
        end else begin
            hsync_o  <= s1_hs;
            vsync_o  <= s1_vs;
            ce_pix_o <= s1_ce;
            if (black) begin
                rgb <= '0;
            end else if (s1_mono) begin
                rgb <= {s1_green, s1_green, s1_green};
            end else begin
                rgb <= s1_ent;
            end
        end
    end

endmodule

// File: tb/tb_video_palette.sv
// Directed bench for video_palette at IDXW=4, CHW=6.
// Stimulus is driven 1 time unit after each rising edge and outputs are sampled there too.
module tb_video_palette;

    localparam int W = 18;

    logic         clock = 1'b0;
    logic         power, ce_pix, pixel, blank, hsync, vsync, mono, wr, rd;
    logic [3:0]   color, waddr;
    logic [W-1:0] wdata, rdata, rgb;
    logic         hsync_o, vsync_o, ce_pix_o, busy;

    int checks = 0;
    int errors = 0;

    localparam logic [W-1:0] WHITE = {3{6'b111111}};
    localparam logic [W-1:0] DEF1  = {3{6'b000100}};
    localparam logic [W-1:0] DEF3  = {3{6'b001100}};
    localparam logic [W-1:0] DEF5  = {3{6'b010101}};
    localparam logic [W-1:0] E2    = {6'b110000, 6'b001000, 6'b010000};
    localparam logic [W-1:0] NEW5  = {6'd50, 6'd17, 6'd33};
    localparam logic [W-1:0] E9    = {6'd3, 6'd40, 6'd7};
    localparam logic [W-1:0] MONO9 = {3{6'd40}};

    video_palette #(.IDXW(4), .CHW(6)) dut (
        .clock(clock), .power(power), .ce_pix(ce_pix), .pixel(pixel),
        .blank(blank), .color(color), .hsync(hsync), .vsync(vsync),
        .mono(mono), .wr(wr), .waddr(waddr), .wdata(wdata), .rd(rd),
        .rdata(rdata), .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .ce_pix_o(ce_pix_o), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Releases reset just after an edge and counts edges until busy drops.
    task automatic run_init(input string tag);
        int n;
        logic bad;
        n = 0;
        bad = 1'b0;
        power = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            if (rgb !== '0) bad = 1'b1;
            step();
            n++;
        end
        chk({tag, "_len"}, W'(n), W'(16));
        chk({tag, "_rgb0"}, W'(bad), W'(0));
    endtask

    initial begin
        power = 1'b0; ce_pix = 1'b0; pixel = 1'b0; blank = 1'b0;
        hsync = 1'b0; vsync = 1'b0; mono = 1'b0; wr = 1'b0; rd = 1'b0;
        color = '0; waddr = '0; wdata = '0;

        #12;
        chk("rst_busy", W'(busy), W'(1));
        chk("rst_rgb", rgb, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_sync", W'({hsync_o, vsync_o, ce_pix_o}), '0);
        step();

        // Host traffic during INIT must be ignored.
        pixel = 1'b1; color = 4'd15;
        wr = 1'b1; rd = 1'b1; waddr = 4'd3; wdata = '1;
        run_init("init1");
        wr = 1'b0; rd = 1'b0;
        chk("busy_rdata_held", rdata, '0);
        step(); step();
        chk("white15", rgb, WHITE);

        color = 4'd1;
        step(); step();
        chk("ramp1", rgb, DEF1);
        color = 4'd3;
        step(); step();
        chk("ramp3_wr_ignored", rgb, DEF3);
        rd = 1'b1; waddr = 4'd3;
        step();
        rd = 1'b0;
        chk("rd3", rdata, DEF3);

        wr = 1'b1; waddr = 4'd2; wdata = E2;
        step();
        wr = 1'b0;
        color = 4'd2;
        step();
        chk("lat_1clk", rgb, DEF3);
        step();
        chk("e2_2clk", rgb, E2);

        hsync = 1'b1; vsync = 1'b1; ce_pix = 1'b1;
        step();
        hsync = 1'b0; vsync = 1'b0; ce_pix = 1'b0;
        chk("sync_d1", W'({hsync_o, vsync_o, ce_pix_o}), W'(3'b000));
        step();
        chk("sync_d2", W'({hsync_o, vsync_o, ce_pix_o}), W'(3'b111));
        step();
        chk("sync_d3", W'({hsync_o, vsync_o, ce_pix_o}), W'(3'b000));

        // Same-cycle write, lookup and readback of entry 5.
        wr = 1'b1; rd = 1'b1; waddr = 4'd5; wdata = NEW5; color = 4'd5;
        step();
        wr = 1'b0; rd = 1'b0;
        chk("rdw_rdata_old", rdata, DEF5);
        step();
        chk("rdw_pix_old", rgb, DEF5);
        step();
        chk("rdw_pix_new", rgb, NEW5);

        color = 4'd15; blank = 1'b1;
        step(); step();
        chk("blank_black", rgb, '0);
        blank = 1'b0; pixel = 1'b0;
        step(); step();
        chk("pixel_black", rgb, '0);
        pixel = 1'b1;

        wr = 1'b1; waddr = 4'd9; wdata = E9;
        step();
        wr = 1'b0;
        color = 4'd9; mono = 1'b1;
        step(); step();
        chk("mono9", rgb, MONO9);
        mono = 1'b0;
        step(); step();
        chk("colour9", rgb, E9);

        // Reset in RUN after host writes.
        rd = 1'b1; waddr = 4'd5;
        step();
        rd = 1'b0;
        color = 4'd5; hsync = 1'b1; ce_pix = 1'b1;
        step(); step();
        chk("pre_rst_rgb", rgb, NEW5);
        chk("pre_rst_rdata", rdata, NEW5);
        #2 power = 1'b0;
        #1;
        chk("async_rgb", rgb, '0);
        chk("async_rdata", rdata, '0);
        chk("async_sync", W'({hsync_o, ce_pix_o}), W'(2'b00));
        chk("async_busy", W'(busy), W'(1));
        step();

        // Reset again mid-INIT once the counter has reached 7.
        power = 1'b1;
        repeat (7) step();
        chk("mid_init_busy", W'(busy), W'(1));
        chk("mid_init_hs", W'(hsync_o), W'(1));
        #2 power = 1'b0;
        #1;
        chk("mid_init_async", W'({hsync_o, ce_pix_o}), W'(2'b00));
        step();
        run_init("init3");
        hsync = 1'b0; ce_pix = 1'b0;
        step(); step();
        chk("default5_back", rgb, DEF5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_palette.md
VIDEO_PALETTE -- requirements
Module: video_palette

Interface
REQ-001 Parameter IDXW, default 4, colour-index width; palette depth is 2^IDXW entries.
REQ-002 Parameter CHW, default 6, per-channel width; legal range IDXW <= CHW <= 4*IDXW.
REQ-003 clock  in  1  system clock; all logic on rising edge.
REQ-004 power  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 ce_pix  in  1  pixel enable, delayed alongside pixel data.
REQ-006 pixel  in  1  pixel-active gate; 0 forces black.
REQ-007 blank  in  1  blanking; 1 forces black.
REQ-008 color  in  IDXW  palette index.
REQ-009 hsync, vsync  in  1 each  sync inputs.
REQ-010 mono  in  1  mode select; 1 = green channel copied to all three channels.
REQ-011 wr  in  1  host write strobe.
REQ-012 waddr  in  IDXW  host write index.
REQ-013 wdata  in  3*CHW  host entry data {R,G,B}.
REQ-014 rd  in  1  host readback strobe.
REQ-015 rdata  out  3*CHW  readback data for the entry addressed by waddr when rd was asserted.
REQ-016 rgb  out  3*CHW  output colour {R,G,B}.
REQ-017 hsync_o, vsync_o, ce_pix_o  out  1 each  delayed sync and enable outputs.
REQ-018 busy  out  1  1 while the palette initialisation walk is running.

Function
REQ-019 State machine states: INIT and RUN. INIT is entered on reset; RUN is entered after the last entry has been written.
REQ-020 INIT: an internal counter runs from 0 to 2^IDXW-1, writing one entry per clock. It moves to RUN on the cycle after it writes entry 2^IDXW-1. INIT takes exactly 2^IDXW clocks.
REQ-021 INIT default entry i: each channel is the CHW most significant bits of i replicated MSB-first ceil(CHW/IDXW) times. This gives a grey ramp. Example at IDXW=4, CHW=6: i=15 gives 111111; i=1 gives 000100.
REQ-022 While busy=1: wr and rd are ignored, rdata is held, and rgb is forced to 0. Sync and ce_pix outputs keep propagating.
REQ-023 Datapath latency is exactly 2 clocks from inputs to rgb, hsync_o, vsync_o and ce_pix_o. Stage 1 registers the inputs. Stage 2 registers the palette read and the gating result. The pipeline advances every clock and is not qualified by ce_pix.
REQ-024 rgb = 0 when the stage-1 copy of pixel is 0 or of blank is 1. Otherwise rgb = palette[color].
REQ-025 When mono=1 and not forced black, rgb = {G,G,G} of the looked-up entry. mono is sampled in stage 1.
REQ-026 In RUN, wr=1 writes wdata to palette[waddr] at the clock edge.
REQ-027 A write and a pixel lookup to the same index in the same cycle is read-before-write: the pixel gets the old value, and the next lookup gets the new value.
REQ-028 In RUN, rd=1 loads rdata with palette[waddr] one clock later. If wr=1 in the same cycle, rdata returns the old value.
REQ-029 Index arithmetic wraps modulo 2^IDXW. The INIT counter cannot exceed 2^IDXW-1.

Reset
REQ-030 power=0 asynchronously forces the following: state INIT, INIT counter 0, busy 1, rgb 0, rdata 0, hsync_o 0, vsync_o 0, ce_pix_o 0, and all pipeline registers 0.
REQ-031 Reset during RUN or mid-INIT discards all host-written entries. The full INIT walk restarts on release.
REQ-032 Deassertion of power takes effect on the first rising edge of clock after release; INIT begins at that edge.

Verification
REQ-033 Release power with IDXW=4, CHW=6 -> busy=1 for exactly 16 clocks, then busy=0. During busy, rgb=0. With pixel=1, blank=0, color=15 afterwards -> rgb=111111_111111_111111 two clocks later.
REQ-034 In RUN, write palette[2]=110000_001000_010000, then pixel=1, color=2 -> rgb equals that value exactly 2 clocks after the input. Pulse hsync for 1 clock -> hsync_o is identical, delayed 2 clocks.
REQ-035 Same-cycle wr to index 5 and lookup of index 5 -> that pixel shows the old entry-5 value; the next cycle's lookup shows the new value. rd on index 5 in the write cycle -> rdata shows the old value.
REQ-036 Toggle blank=1 and pixel=0 separately with color=15 -> rgb=0 in each case. Set mono=1 on entry {R=3,G=40,B=7} -> rgb={40,40,40}.
REQ-037 Assert power=0 mid-INIT at counter 7 and in RUN after host writes -> outputs are 0 immediately (asynchronously). After release: 16-clock INIT, and the previously written index returns the grey-ramp default.
REQ-038 wr pulse during busy=1 targeting index 3 -> after INIT, entry 3 holds the default value 001100_001100_001100.
